// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU op codes, divider states and the ID->EX bus layout for the execute stage.
package ex_stage_pkg;

  localparam int unsigned ID_TO_EX_WD  = 144;
  localparam int unsigned EX_TO_MEM_WD = 76;
  localparam int unsigned EX_TO_ID_WD  = 38;
  localparam int unsigned STALL_WD     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // ADD must stay at zero so an all-zero bubble decodes as a harmless add.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_DIV  = 4'd12,
    ALU_DIVU = 4'd13,
    ALU_MFHI = 4'd14,
    ALU_MFLO = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_rdata2;
  } id_to_ex_t;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Restoring shift-subtract divider: magnitudes are divided, signs are re-applied in DONE.
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam int unsigned CW = $clog2(DIV_ITERS + 1);

  div_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dsor_q, dsor_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [32:0] shifted, trial;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsor_d  = dsor_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dsor_q};
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d = DIV_BUSY;
          sa_d    = signed_i & dividend_i[31];
          sb_d    = signed_i & divisor_i[31];
          quo_d   = neg_if(dividend_i, sa_d);
          dsor_d  = neg_if(divisor_i, sb_d);
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      DIV_BUSY: begin
        // Partial remainder stays below the divisor, so bit 32 of trial is a clean borrow flag.
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_ITERS - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsor_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsor_q  <= dsor_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign busy_o      = ((state_q == DIV_IDLE) && start_i) || (state_q == DIV_BUSY);
  assign done_o      = (state_q == DIV_DONE);
  assign quotient_o  = neg_if(quo_q, sa_q ^ sb_q);
  assign remainder_o = neg_if(rem_q, sa_q);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID->EX register, ALU, data-SRAM request, HI/LO and divider hand-off.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_to_ex_t   r_q, r_d;
  logic        load;
  logic        div_done_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] ex_result;
  logic        is_div, div_start, div_fin;
  logic [31:0] div_quo, div_rem;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:4], stall[1:0]};

  always_comb begin
    r_d  = r_q;
    load = 1'b1;
    if (stall[2] == STOP && stall[3] == NO_STOP) r_d = '0;
    else if (stall[2] == NO_STOP)                r_d = id_to_ex_bus;
    else                                         load = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_q <= '0;
    else      r_q <= r_d;
  end

  // A held DIV that already finished must not restart; any fresh load re-arms issue.
  always_ff @(posedge clk) begin
    if (!rst)         div_done_q <= 1'b0;
    else if (load)    div_done_q <= 1'b0;
    else if (div_fin) div_done_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_fin) begin
      hi_q <= div_rem;
      lo_q <= div_quo;
    end
  end

  assign is_div    = (r_q.alu_op == ALU_DIV) || (r_q.alu_op == ALU_DIVU);
  assign div_start = is_div && !div_done_q;

  div_iter #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .signed_i   (r_q.alu_op == ALU_DIV),
    .dividend_i (r_q.src1),
    .divisor_i  (r_q.src2),
    .busy_o     (stallreq_for_ex),
    .done_o     (div_fin),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  always_comb begin
    ex_result = '0;
    case (r_q.alu_op)
      ALU_ADD:  ex_result = r_q.src1 + r_q.src2;
      ALU_SUB:  ex_result = r_q.src1 - r_q.src2;
      ALU_SLT:  ex_result = {31'b0, $signed(r_q.src1) < $signed(r_q.src2)};
      ALU_SLTU: ex_result = {31'b0, r_q.src1 < r_q.src2};
      ALU_AND:  ex_result = r_q.src1 & r_q.src2;
      ALU_OR:   ex_result = r_q.src1 | r_q.src2;
      ALU_XOR:  ex_result = r_q.src1 ^ r_q.src2;
      ALU_NOR:  ex_result = ~(r_q.src1 | r_q.src2);
      ALU_SLL:  ex_result = r_q.src2 << r_q.src1[4:0];
      ALU_SRL:  ex_result = r_q.src2 >> r_q.src1[4:0];
      ALU_SRA:  ex_result = $unsigned($signed(r_q.src2) >>> r_q.src1[4:0]);
      ALU_LUI:  ex_result = {r_q.src2[15:0], 16'b0};
      ALU_MFHI: ex_result = hi_q;
      ALU_MFLO: ex_result = lo_q;
      default:  ex_result = '0;
    endcase
  end

  assign data_sram_en    = r_q.data_ram_en;
  assign data_sram_wen   = r_q.data_ram_wen;
  assign data_sram_addr  = r_q.src1 + r_q.src2;
  assign data_sram_wdata = r_q.rf_rdata2;

  assign ex_to_mem_bus = {r_q.pc, r_q.data_ram_en, r_q.data_ram_wen, r_q.sel_rf_res,
                          r_q.rf_we, r_q.rf_waddr, ex_result};
  assign ex_to_id_bus  = {r_q.rf_we, r_q.rf_waddr, ex_result};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: single-cycle ALU/memory vectors plus divider sequences.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   ext_stall = '0;
  logic [5:0]   stall_w;
  logic [143:0] id_bus = '0;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         stallreq;
  logic [31:0]  res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // The bench plays pipeline controller: a divider request holds IF..EX.
  assign stall_w = stallreq ? 6'b001111 : ext_stall;
  assign res     = ex_to_mem_bus[31:0];

  ex_stage #(.DIV_ITERS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall_w),
    .id_to_ex_bus   (id_bus),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .ex_to_id_bus   (ex_to_id_bus),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .stallreq_for_ex(stallreq)
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        en;
    logic [3:0]  wen;
    logic        sel;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] rd2;
    logic [5:0]  st;
    logic [31:0] res;
    logic [31:0] addr;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [143:0] mk(input logic [3:0] op, input logic [31:0] s1,
                                      input logic [31:0] s2);
    return {32'h0040_0100, op, s1, s2, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0};
  endfunction

  task automatic div_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic hold_ext, output int n);
    @(negedge clk);
    ext_stall = '0;
    id_bus    = mk(op, a, b);
    @(posedge clk);
    @(negedge clk);
    chk("div_result_zero", res, 32'h0);
    ext_stall = hold_ext ? 6'b001111 : 6'b000000;
    id_bus    = mk(ALU_MFLO, 32'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stallreq) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_hilo(input string name, input logic [31:0] exp_lo,
                            input logic [31:0] exp_hi);
    @(posedge clk); #1;
    chk({name, "_lo"}, res, exp_lo);
    @(negedge clk);
    id_bus = mk(ALU_MFHI, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk({name, "_hi"}, res, exp_hi);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;
    logic bub;

    vt.push_back('{32'h00400000, ALU_MFHI, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h0, 6'h00, 32'h0, 32'h0});
    vt.push_back('{32'h00400004, ALU_MFLO, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h0, 6'h00, 32'h0, 32'h0});
    vt.push_back('{32'h00400008, ALU_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0, 6'h00, 32'h80000000, 32'h80000000});
    vt.push_back('{32'h0040000C, ALU_SLT, 32'h7FFFFFFF, 32'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0, 6'h00, 32'h0, 32'h80000000});
    vt.push_back('{32'h00400010, ALU_SLTU, 32'h7FFFFFFF, 32'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0, 6'h00, 32'h0, 32'h80000000});
    vt.push_back('{32'h00400014, ALU_SUB, 32'h0, 32'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h0, 6'h00, 32'hFFFFFFFF, 32'h1});
    vt.push_back('{32'h00400018, ALU_SLT, 32'hFFFFFFFF, 32'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h0, 6'h00, 32'h1, 32'h0});
    vt.push_back('{32'h0040001C, ALU_SLTU, 32'hFFFFFFFF, 32'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h0, 6'h00, 32'h0, 32'h0});
    vt.push_back('{32'h00400020, ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0, 6'h00, 32'h00F000F0, 32'h00E100E0});
    vt.push_back('{32'h00400024, ALU_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0, 6'h00, 32'hFFF0FFF0, 32'h00E100E0});
    vt.push_back('{32'h00400028, ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0, 6'h00, 32'hFF00FF00, 32'h00E100E0});
    vt.push_back('{32'h0040002C, ALU_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0, 6'h00, 32'h000F000F, 32'h00E100E0});
    vt.push_back('{32'h00400030, ALU_SLL, 32'h4, 32'h80000001, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'h0, 6'h00, 32'h00000010, 32'h80000005});
    vt.push_back('{32'h00400034, ALU_SRL, 32'h4, 32'h80000001, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'h0, 6'h00, 32'h08000000, 32'h80000005});
    vt.push_back('{32'h00400038, ALU_SRA, 32'h4, 32'h80000001, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'h0, 6'h00, 32'hF8000000, 32'h80000005});
    vt.push_back('{32'h0040003C, ALU_SLL, 32'h24, 32'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'h0, 6'h00, 32'h00000010, 32'h25});
    vt.push_back('{32'h00400040, ALU_SRA, 32'h1F, 32'h80000000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h0, 6'h00, 32'hFFFFFFFF, 32'h8000001F});
    vt.push_back('{32'h00400044, ALU_LUI, 32'h0, 32'hABCD1234, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h0, 6'h00, 32'h12340000, 32'hABCD1234});
    vt.push_back('{32'h00400048, ALU_ADD, 32'h1000, 32'h4, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 6'h00, 32'h1004, 32'h1004});
    vt.push_back('{32'h0040004C, ALU_ADD, 32'h1000, 32'h4, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 6'b000100, 32'h0, 32'h0});
    vt.push_back('{32'h00400050, ALU_XOR, 32'h1003, 32'h5, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h12345678, 6'h00, 32'h1006, 32'h1008});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_bus", ex_to_mem_bus, 76'h0);
    chk("rst_id_bus", ex_to_id_bus, 38'h0);
    chk("rst_sram_en", data_sram_en, 1'b0);
    chk("rst_stallreq", stallreq, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) begin
      v = vt[i];
      bub = (v.st == 6'b000100);
      @(negedge clk);
      ext_stall = v.st;
      id_bus = {v.pc, v.op, v.s1, v.s2, v.en, v.wen, v.sel, v.we, v.wa, v.rd2};
      @(posedge clk); #1;
      chk($sformatf("v%0d_mem_bus", i), ex_to_mem_bus,
          bub ? 76'h0 : {v.pc, v.en, v.wen, v.sel, v.we, v.wa, v.res});
      chk($sformatf("v%0d_id_bus", i), ex_to_id_bus, bub ? 38'h0 : {v.we, v.wa, v.res});
      chk($sformatf("v%0d_sram_en", i), data_sram_en, bub ? 1'b0 : v.en);
      chk($sformatf("v%0d_sram_wen", i), data_sram_wen, bub ? 4'h0 : v.wen);
      chk($sformatf("v%0d_sram_addr", i), data_sram_addr, bub ? 32'h0 : v.addr);
      chk($sformatf("v%0d_sram_wdata", i), data_sram_wdata, bub ? 32'h0 : v.rd2);
      chk($sformatf("v%0d_stallreq", i), stallreq, 1'b0);
    end

    // Hold: stall[2] and stall[3] both asserted keep the previous instruction
    @(negedge clk);
    ext_stall = '0;
    id_bus = mk(ALU_ADD, 32'd3, 32'd4);
    @(posedge clk); #1;
    chk("hold_pre", res, 32'd7);
    @(negedge clk);
    ext_stall = 6'b001111;
    id_bus = mk(ALU_SUB, 32'd9, 32'd1);
    @(posedge clk); #1;
    chk("hold_keep", res, 32'd7);
    @(negedge clk);
    ext_stall = '0;

    // Divides
    div_run(ALU_DIVU, 32'd100, 32'd7, 1'b0, n);
    chk("divu_stall_cycles", n, 33);
    check_hilo("divu_100_7", 32'd14, 32'd2);

    div_run(ALU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, n);
    chk("div_stall_cycles", n, 33);
    check_hilo("div_m7_2", 32'hFFFFFFFD, 32'hFFFFFFFF);

    div_run(ALU_DIVU, 32'd5, 32'd0, 1'b0, n);
    chk("divz_stall_cycles", n, 33);
    check_hilo("divu_5_0", 32'hFFFFFFFF, 32'd5);

    // DIV kept in EX by an external stall after DONE must not reissue
    div_run(ALU_DIV, 32'd20, 32'd3, 1'b1, n);
    chk("held_div_stall_cycles", n, 33);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("held_no_reissue_%0d", k), stallreq, 1'b0);
    end
    ext_stall = '0;
    check_hilo("held_div", 32'd6, 32'd2);

    // Reset in the middle of a divide
    @(negedge clk);
    id_bus = mk(ALU_DIVU, 32'd1000, 32'd3);
    @(posedge clk);
    repeat (10) @(negedge clk);
    chk("abort_busy_before", stallreq, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_stallreq", stallreq, 1'b0);
    chk("abort_mem_bus", ex_to_mem_bus, 76'h0);
    @(negedge clk);
    rst = 1'b1;
    id_bus = mk(ALU_MFHI, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("abort_hi", res, 32'h0);
    chk("abort_fsm_idle", stallreq, 1'b0);
    @(negedge clk);
    id_bus = mk(ALU_MFLO, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("abort_lo", res, 32'h0);
    chk("abort_still_idle", stallreq, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
